// File: rtl/frame_serializer.sv
// frame_serializer: takes one WIDTH-bit word through a valid/ready handshake
// and sends it as an asynchronous serial frame on ser_data. The frame is a
// start bit, the data bits, an optional parity bit, then one or two stop bits.
// Every bit is held for prescale+1 clocks.
//
// Handshake: data_ready is high exactly when the FSM is in IDLE. A word is
// accepted on a rising edge of clk_ser where data_valid and data_ready are
// both high. The word, parity settings, stop-bit count and prescale are
// captured only at that edge. After the accept, data_ready stays low until
// the frame ends. data_valid has no effect while data_ready is low, and
// nothing is queued.
module frame_serializer #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk_ser,
    input  logic                  rst_ser,
    input  logic [WIDTH-1:0]      P_DATA_ser,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  ser_data,
    output logic                  busy,
    output logic                  ser_done,
    output logic [2:0]            fsm_state_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t                state_q;
    logic [WIDTH-1:0]      shift_q;
    logic [WIDTH-1:0]      shift_d;
    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;
    logic [PRESCALE_W-1:0] presc_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;
    logic                  ser_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  ready_q;
    logic                  bit_end;
    logic                  data_bit;

    // The current bit ends on the edge where its down-counter reaches zero.
    assign bit_end = (cnt_q == '0);

    // Next data bit to drive and the shift register after it has been sent.
    always_comb begin
        shift_d  = shift_q;
        data_bit = 1'b1;
        if (LSB_FIRST) begin
            data_bit = shift_q[0];
            shift_d  = shift_q >> 1;
        end else begin
            data_bit = shift_q[WIDTH-1];
            shift_d  = shift_q << 1;
        end
    end

    // Bit-period counter: count down, then reload for the next bit.
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (bit_end) begin
            cnt_d = presc_q;
        end
    end

    // Frame FSM. All outputs are registered and change on the same edge as the state.
    always_ff @(posedge clk_ser or negedge rst_ser) begin
        if (!rst_ser) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            ser_data_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ser_data_q <= 1'b1;
                    busy_q     <= 1'b0;
                    ready_q    <= 1'b1;
                    if (data_valid && ready_q) begin
                        shift_q    <= P_DATA_ser;
                        par_en_q   <= par_en;
                        // Even parity is the XOR of the data bits; odd parity inverts it.
                        par_bit_q  <= (^P_DATA_ser) ^ par_typ;
                        stop2_q    <= stop2;
                        presc_q    <= prescale;
                        cnt_q      <= prescale;
                        idx_q      <= '0;
                        state_q    <= S_START;
                        ser_data_q <= 1'b0;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                    end
                end
                S_START: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q    <= S_DATA;
                        ser_data_q <= data_bit;
                        shift_q    <= shift_d;
                        idx_q      <= '0;
                    end
                end
                S_DATA: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if (idx_q == LAST_IDX) begin
                            if (par_en_q) begin
                                state_q    <= S_PARITY;
                                ser_data_q <= par_bit_q;
                            end else begin
                                state_q    <= S_STOP1;
                                ser_data_q <= 1'b1;
                            end
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            ser_data_q <= data_bit;
                            shift_q    <= shift_d;
                        end
                    end
                end
                S_PARITY: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q    <= S_STOP1;
                        ser_data_q <= 1'b1;
                    end
                end
                S_STOP1: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        if (stop2_q) begin
                            state_q    <= S_STOP2;
                            ser_data_q <= 1'b1;
                        end else begin
                            state_q    <= S_IDLE;
                            ser_data_q <= 1'b1;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            ready_q    <= 1'b1;
                        end
                    end
                end
                S_STOP2: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q    <= S_IDLE;
                        ser_data_q <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    ser_data_q <= 1'b1;
                    busy_q     <= 1'b0;
                    ready_q    <= 1'b1;
                end
            endcase
        end
    end

    assign ser_data    = ser_data_q;
    assign busy        = busy_q;
    assign ser_done    = done_q;
    assign data_ready  = ready_q;
    assign fsm_state_o = state_q;

endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
Parametrised successor to the basic shift-out serializer. It accepts a WIDTH-bit parallel word through a valid/ready handshake and emits a complete asynchronous-serial frame on one line, optionally with a parity bit. A frame is start, data, optional parity, then 1 or 2 stop bits, at a programmable bit period and a selectable bit order. It sits between the register/FIFO side and the TX pad of the UART path.

Parameters:
WIDTH, 8, data bits per frame; legal 1..16.
PRESCALE_W, 8, width of the prescale input.
LSB_FIRST, 1, 1 = data bit 0 sent first; 0 = data bit WIDTH-1 sent first.

Ports:
clk_ser  input  1  clock; all state on rising edge.
rst_ser  input  1  asynchronous reset, active low.
P_DATA_ser  input  WIDTH  parallel word; sampled only on accept.
data_valid  input  1  word present on P_DATA_ser.
data_ready  output  1  block can accept; accept = data_valid & data_ready at a rising edge.
par_en  input  1  1 = insert parity bit; sampled on accept.
par_typ  input  1  0 = even parity, 1 = odd parity; sampled on accept.
stop2  input  1  1 = two stop bits, 0 = one; sampled on accept.
prescale  input  PRESCALE_W  bit period = prescale+1 clocks; sampled on accept.
ser_data  output  1  serial line; idles high.
busy  output  1  high from the accept edge until the frame ends.
ser_done  output  1  one-cycle pulse after the final stop bit.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE; ser_data = 1; busy = 0; ser_done = 0; data_ready = 1.
  - Internal counters, shift register and latched configuration are cleared.
  - A frame in flight is abandoned; it does not resume after reset release.
- All outputs are registered. data_ready = (state == IDLE).
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - ser_data = 1.
  - On accept: latch P_DATA_ser, par_en, par_typ, stop2 and prescale; compute parity from the latched word.
  - Same edge: state -> START, ser_data <= 0, busy <= 1, cycle counter <= latched prescale.
- Bit timing:
  - Every bit (start, data, parity, stop) drives ser_data for exactly prescale+1 cycles.
  - The cycle counter decrements each clock; at 0 the next bit is driven on that edge and the counter reloads.
  - prescale = 0 gives one bit per clock.
- START -> DATA.
- DATA:
  - Drives WIDTH bits, order set by LSB_FIRST; a bit index counts 0..WIDTH-1.
  - After the last data bit: -> PARITY if par_en, else -> STOP1.
- PARITY: bit = XOR of data bits for even parity, inverted for odd. -> STOP1.
- STOP1: ser_data = 1. -> STOP2 if stop2, else frame end.
- STOP2: ser_data = 1. -> frame end.
- Frame end (edge where the last stop bit's counter is 0):
  - state <= IDLE, busy <= 0, ser_done <= 1 for exactly one cycle, ser_data stays 1.
- Frame length in clocks: (2 + WIDTH + par_en + stop2) * (prescale+1).
- Back-to-back frames: data_valid held high gives exactly one IDLE cycle (line high) between the last stop bit and the next start bit. The next accept occurs in the ser_done cycle.
- Input changes while busy are ignored: data, config and prescale are latched only at accept. data_valid while busy has no effect.
- No internal buffering beyond the single latched word.

Test Plan:
- Reset values: hold rst_ser low, then release with data_valid=0 -> ser_data=1, busy=0, ser_done=0, data_ready=1. Line stays idle high for 20 cycles.
- Basic frame: WIDTH=8, LSB_FIRST=1, prescale=0, par_en=1, par_typ=0, stop2=0, data 0xA5.
  - Response: one bit per clock: 0,1,0,1,0,0,1,0,1,0,1.
  - busy is high for 11 cycles; ser_done pulses the cycle after the stop bit.
  - Repeat with par_typ=1 -> parity bit becomes 1.
- Prescale and two stop bits: prescale=3, par_en=0, stop2=1, data 0x00.
  - Response: each bit is held 4 clocks; the frame lasts 44 clocks (start + 8 zeros + 2 stop bits high).
  - ser_done pulses exactly once; changing P_DATA_ser and prescale mid-frame does not alter the frame.
- MSB order: LSB_FIRST=0, prescale=0, par_en=0, data 0x01 -> 0,0,0,0,0,0,0,0,1,1.
- Back-to-back: data_valid held high with 0x55, then 0x0F -> second start bit appears exactly 1 idle-high cycle after the first frame's stop bit. data_ready pulses once per frame.
- Reset mid-frame: assert rst_ser during DATA of 0x00 -> ser_data=1 immediately (asynchronous), busy=0.
  - After release: no ser_done pulse and no residual bits.
  - A new accept of 0xFF produces a clean full frame.
